stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and one registered output stage. Each cycle it selects one input channel, either by an externally driven select (fixed mode) or by round-robin arbitration, and forwards that channel's beat to a single output register. It merges several producer streams onto one consumer port in the datapath and replaces the earlier combinational 3:1 single-bit selector.

---
 rtl/stream_mux_rr.sv | 130 +++++++++++++
 tb/tb_stream_mux_rr.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit valid/ready stream multiplexer feeding a
// single registered output stage. The channel is chosen either by an external
// select (mode=0) or by a round-robin search that starts after the last
// granted channel (mode=1). The round-robin pointer follows every transfer in
// both modes, so fairness carries on across mode switches.
module stream_mux_rr #(
  parameter  int N  = 3,
  parameter  int W  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [CW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  // Pointer to the most recently granted channel; the round-robin search
  // begins one past it.
  logic [CW-1:0] ptr;

  // Output register can accept a beat: empty, or being drained this cycle.
  logic free;

  // Fixed-mode grant qualifier.
  logic fix_valid;

  // Round-robin search result.
  logic          rr_found;
  logic [CW-1:0] rr_grant;

  // Selected grant after the mode mux.
  logic          grant_valid;
  logic [CW-1:0] grant;

  // Data of the granted channel and the transfer strobe.
  logic [W-1:0] grant_data;
  logic         fire;

  assign free = !out_valid || out_ready;

  // Fixed mode: qualify sel against in_valid. An index >= N matches no
  // channel, so it grants nothing and never indexes past in_valid.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the loop can leave it unassigned and infer a latch.
    fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == CW'(i)) begin
        fix_valid = in_valid[i];
      end
    end
  end

  // Round-robin: visit ptr+1, ptr+2, ... modulo N and take the first valid
  // channel. The constant inner index keeps every bit-select in range.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!rr_found && ((int'(ptr) + k) % N == i) && in_valid[i]) begin
          rr_found = 1'b1;
          rr_grant = CW'(i);
        end
      end
    end
  end

  // Choose the active grant source.
  always_comb begin
    if (mode) begin
      grant_valid = rr_found;
      grant       = rr_grant;
    end else begin
      grant_valid = fix_valid;
      grant       = sel;
    end
  end

  // Ready decode and data mux. in_ready depends only on the grant and the
  // output-register state, never on in_data.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == CW'(i)) begin
        in_ready[i] = free && grant_valid;
        grant_data  = in_data[i*W +: W];
      end
    end
  end

  // A grant only exists for a channel with in_valid set, so a granted,
  // free cycle is a transfer.
  assign fire = free && grant_valid;

  // Output register: load on transfer, clear valid on drain, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (fire) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: tracks the granted channel on every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CW'(N - 1);
    end else if (fire) begin
      ptr <= grant;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: a table of directed vectors on a 3x8 instance,
// hand sequences for asynchronous reset, and a randomized 5x16 instance
// checked against a behavioral model, with a scoreboard on the output side.
module tb_stream_mux_rr;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int N5 = 5;
  localparam int W5 = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 3-channel instance
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready;

  // 5-channel instance
  logic             mode5;
  logic [2:0]       sel5;
  logic [N5*W5-1:0] in_data5;
  logic [N5-1:0]    in_valid5;
  logic [N5-1:0]    in_ready5;
  logic [W5-1:0]    out_data5;
  logic [2:0]       out_chan5;
  logic             out_valid5;
  logic             out_ready5;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.N(N5), .W(W5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
    .out_ready(out_ready5)
  );

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [2:0]  vld;
    logic [23:0] data;
    logic        ordy;
    logic [2:0]  exp_rdy;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  chan;
  } beat_t;

  vec_t  tbl [22];
  beat_t sb3[$];
  beat_t sb5[$];
  bit    m_valid;
  int    n_checks;
  int    n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one vector just after a falling edge; compare, update scoreboard,
  // then advance to the next falling edge.
  task automatic step3(input vec_t v);
    beat_t b;
    mode      = v.mode;
    sel       = v.sel;
    in_valid  = v.vld;
    in_data   = v.data;
    out_ready = v.ordy;
    #1;
    check("in_ready", in_ready, v.exp_rdy);
    check("out_valid", out_valid, m_valid);
    if (m_valid && sb3.size() > 0) begin
      check("out_data", out_data, sb3[0].data);
      check("out_chan", out_chan, sb3[0].chan);
      if (v.ordy) void'(sb3.pop_front());
    end
    if (v.exp_rdy != 3'b000) begin
      for (int c = 0; c < N; c++) begin
        if (v.exp_rdy[c]) begin
          b.data = 16'(v.data[c*W +: W]);
          b.chan = 3'(c);
        end
      end
      sb3.push_back(b);
      m_valid = 1'b1;
    end else if (v.ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // 5-channel model state
  int    m5_ptr;
  bit    m5_valid;
  int    seq  [N5];
  int    sent [N5];
  int    recv [N5];
  int    hist [$];

  // One randomized-or-forced cycle on the 5-channel instance.
  task automatic step5();
    bit          gv;
    int          g;
    bit          free5;
    logic [4:0]  exp_rdy;
    beat_t       b;
    for (int c = 0; c < N5; c++) in_data5[c*W5 +: W5] = {4'(c), 12'(seq[c])};
    #1;
    gv = 1'b0;
    g  = 0;
    if (mode5) begin
      for (int k = 1; k <= N5; k++) begin
        int c;
        c = (m5_ptr + k) % N5;
        if (!gv && in_valid5[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end else if (int'(sel5) < N5) begin
      gv = in_valid5[sel5];
      g  = int'(sel5);
    end
    free5   = !m5_valid || out_ready5;
    exp_rdy = (free5 && gv) ? 5'(1 << g) : 5'b0;
    check("ready5_onehot0", 32'($onehot0(in_ready5)), 32'd1);
    check("in_ready5", in_ready5, exp_rdy);
    check("out_valid5", out_valid5, m5_valid);
    if (m5_valid && sb5.size() > 0) begin
      check("out_data5", out_data5, sb5[0].data);
      check("out_chan5", out_chan5, sb5[0].chan);
    end
    if (out_valid5 && out_ready5 && int'(out_chan5) < N5) recv[out_chan5]++;
    if (m5_valid && out_ready5 && sb5.size() > 0) void'(sb5.pop_front());
    if (free5 && gv) begin
      b.data = in_data5[g*W5 +: W5];
      b.chan = 3'(g);
      sb5.push_back(b);
      sent[g]++;
      seq[g]++;
      m5_ptr   = g;
      m5_valid = 1'b1;
    end else if (out_ready5) begin
      m5_valid = 1'b0;
    end
    for (int c = 0; c < N5; c++) if (in_ready5[c] && in_valid5[c]) hist.push_back(c);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    m5_valid = 1'b0;
    m5_ptr   = N5 - 1;
    for (int c = 0; c < N5; c++) begin
      seq[c]  = 0;
      sent[c] = 0;
      recv[c] = 0;
    end

    // mode, sel, in_valid, in_data {ch2,ch1,ch0}, out_ready, expected in_ready
    tbl[0]  = '{1'b1, 2'd0, 3'b111, 24'h030201, 1'b1, 3'b001};
    tbl[1]  = '{1'b1, 2'd0, 3'b111, 24'h131211, 1'b1, 3'b010};
    tbl[2]  = '{1'b1, 2'd0, 3'b111, 24'h232221, 1'b1, 3'b100};
    tbl[3]  = '{1'b1, 2'd0, 3'b111, 24'h333231, 1'b1, 3'b001};
    tbl[4]  = '{1'b0, 2'd2, 3'b100, 24'hA50000, 1'b1, 3'b100};
    tbl[5]  = '{1'b0, 2'd3, 3'b100, 24'hB60000, 1'b1, 3'b000};
    tbl[6]  = '{1'b0, 2'd3, 3'b100, 24'hB60000, 1'b1, 3'b000};
    tbl[7]  = '{1'b0, 2'd1, 3'b010, 24'h003C00, 1'b1, 3'b010};
    for (int r = 8; r <= 12; r++)
      tbl[r] = '{1'b0, 2'd1, 3'b010, 24'h007700, 1'b0, 3'b000};
    tbl[13] = '{1'b0, 2'd1, 3'b010, 24'h007700, 1'b1, 3'b010};
    tbl[14] = '{1'b0, 2'd0, 3'b001, 24'h000011, 1'b1, 3'b001};
    tbl[15] = '{1'b1, 2'd0, 3'b101, 24'h330022, 1'b1, 3'b100};
    tbl[16] = '{1'b1, 2'd0, 3'b101, 24'h440055, 1'b1, 3'b001};
    tbl[17] = '{1'b1, 2'd0, 3'b101, 24'h660077, 1'b1, 3'b100};
    tbl[18] = '{1'b0, 2'd1, 3'b111, 24'h888888, 1'b1, 3'b010};
    tbl[19] = '{1'b1, 2'd1, 3'b111, 24'h999999, 1'b1, 3'b100};
    tbl[20] = '{1'b1, 2'd0, 3'b000, 24'h000000, 1'b1, 3'b000};
    tbl[21] = '{1'b1, 2'd0, 3'b000, 24'h000000, 1'b1, 3'b000};

    mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    mode5 = 1'b0; sel5 = '0; in_data5 = '0; in_valid5 = '0; out_ready5 = 1'b0;
    rst_n = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_chan", out_chan, 2'd0);
    check("rst_in_ready", in_ready, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 22; r++) step3(tbl[r]);

    // Load a beat, then assert reset mid-cycle: outputs clear with no edge.
    step3('{1'b1, 2'd0, 3'b111, 24'hCCBBAA, 1'b1, 3'b001});
    in_valid  = 3'b000;
    out_ready = 1'b0;
    #2;
    check("pre_rst_out_valid", out_valid, 1'b1);
    check("pre_rst_out_data", out_data, 8'hAA);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_out_data", out_data, 8'h00);
    check("async_rst_out_chan", out_chan, 2'd0);
    check("async_rst_in_ready", in_ready, 3'b000);
    sb3.delete();
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer is back at N-1, so round-robin restarts at channel 0.
    step3('{1'b1, 2'd0, 3'b111, 24'h030201, 1'b1, 3'b001});
    step3('{1'b1, 2'd0, 3'b111, 24'h131211, 1'b1, 3'b010});
    step3('{1'b1, 2'd0, 3'b000, 24'h000000, 1'b1, 3'b000});
    step3('{1'b1, 2'd0, 3'b000, 24'h000000, 1'b1, 3'b000});

    // Randomized 5-channel run, including illegal select values 5..7.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 63) == 0) mode5 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) sel5 = 3'($urandom_range(0, 7));
      in_valid5  = 5'($urandom_range(0, 31));
      out_ready5 = ($urandom_range(0, 3) != 0);
      step5();
    end

    // Fairness: round-robin, all valid, output always ready.
    hist.delete();
    mode5      = 1'b1;
    in_valid5  = '1;
    out_ready5 = 1'b1;
    for (int cyc = 0; cyc < 4 * N5; cyc++) step5();
    for (int k = N5 - 1; k < hist.size(); k++) begin
      for (int c = 0; c < N5; c++) begin
        int cnt;
        cnt = 0;
        for (int j = k - N5 + 1; j <= k; j++) if (hist[j] == c) cnt++;
        check("fairness_window", cnt, 1);
      end
    end
    check("fairness_grants", hist.size(), 4 * N5);

    // Drain and account for every beat per channel.
    in_valid5  = '0;
    out_ready5 = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) step5();
    check("sb5_empty", sb5.size(), 0);
    for (int c = 0; c < N5; c++) check("beats_per_chan", recv[c], sent[c]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
